// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the pipeline hazard scheduler:
//   - REGFILE_ADDRESS_LEN : register-file address width (4 -> R0..R15)
//   - STALL_CNT_W         : width of the saturating stall counter (16)
//   - sb_entry_t          : one scoreboard entry {valid, dest, wb_en, mem_read}
//   - SB_EMPTY            : an invalid (bubble) scoreboard entry
//   - stall_sat_inc()     : saturating increment used by the stall counter
// -----------------------------------------------------------------------------
package pipe_pkg;

    localparam int REGFILE_ADDRESS_LEN = 4;
    localparam int STALL_CNT_W         = 16;

    localparam logic [STALL_CNT_W-1:0] STALL_CNT_MAX  = {STALL_CNT_W{1'b1}};
    localparam logic [STALL_CNT_W-1:0] STALL_CNT_ONE  = {{(STALL_CNT_W-1){1'b0}}, 1'b1};
    localparam logic [STALL_CNT_W-1:0] STALL_CNT_ZERO = {STALL_CNT_W{1'b0}};

    typedef struct packed {
        logic                           valid;
        logic [REGFILE_ADDRESS_LEN-1:0] dest;
        logic                           wb_en;
        logic                           mem_read;
    } sb_entry_t;

    localparam sb_entry_t SB_EMPTY = '{
        valid:    1'b0,
        dest:     {REGFILE_ADDRESS_LEN{1'b0}},
        wb_en:    1'b0,
        mem_read: 1'b0
    };

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [STALL_CNT_W-1:0] stall_sat_inc(
        input logic [STALL_CNT_W-1:0] value
    );
        logic [STALL_CNT_W-1:0] next_value;
        if (value == STALL_CNT_MAX) begin
            next_value = value;
        end else begin
            next_value = value + STALL_CNT_ONE;
        end
        return next_value;
    endfunction

endpackage

// File: rtl/sb_match.sv
// -----------------------------------------------------------------------------
// sb_match
// Compares one scoreboard entry against one source register address.
// Ports:
//   i_entry     : scoreboard entry under test
//   i_src       : source register address read by the ID instruction
//   i_load_only : when 1, only an entry produced by a load can match
//   o_match     : entry is a live register-file producer of i_src
// Address 15 is compared like any other register.
// -----------------------------------------------------------------------------
module sb_match
    import pipe_pkg::*;
(
    input  sb_entry_t                      i_entry,
    input  logic [REGFILE_ADDRESS_LEN-1:0] i_src,
    input  logic                           i_load_only,
    output logic                           o_match
);

    assign o_match = i_entry.valid
                   & i_entry.wb_en
                   & (i_entry.dest == i_src)
                   & (~i_load_only | i_entry.mem_read);

endmodule

// File: rtl/pipe_sched.sv
// -----------------------------------------------------------------------------
// pipe_sched
// Scoreboard-based hazard detection for a 5-stage pipeline. Tracks the
// instructions currently in EXE and MEM and stalls the ID instruction when it
// reads a register one of them will still write.
//
// Ports:
//   clk          : pipeline clock
//   rst          : synchronous active-high reset
//   id_valid     : ID holds a real instruction
//   id_src1      : Rn address in ID
//   id_src2      : second source address in ID (Rm, or Rd for stores)
//   id_two_src   : id_src2 is actually read
//   id_dest      : Rd address in ID
//   id_wb_en     : ID instruction writes the register file
//   id_mem_read  : ID instruction is a load
//   branch_taken : branch resolved taken in EXE this cycle
//   hazard       : insert bubble into ID/EXE (combinational)
//   freeze       : hold PC and IF/ID (combinational, equals hazard)
//   flush        : clear IF/ID and ID/EXE (combinational, equals branch_taken)
//   stall_count  : saturating count of hazard cycles
//
// Build option:
//   PIPE_SCHED_FORWARDING_EN defined   -> only a load sitting in EXE stalls ID
//                                         (load-use, one stall cycle).
//   PIPE_SCHED_FORWARDING_EN undefined -> any producer in EXE or MEM stalls ID.
// -----------------------------------------------------------------------------
module pipe_sched
    import pipe_pkg::*;
(
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           id_valid,
    input  logic [REGFILE_ADDRESS_LEN-1:0] id_src1,
    input  logic [REGFILE_ADDRESS_LEN-1:0] id_src2,
    input  logic                           id_two_src,
    input  logic [REGFILE_ADDRESS_LEN-1:0] id_dest,
    input  logic                           id_wb_en,
    input  logic                           id_mem_read,
    input  logic                           branch_taken,
    output logic                           hazard,
    output logic                           freeze,
    output logic                           flush,
    output logic [STALL_CNT_W-1:0]         stall_count
);

    sb_entry_t              r_exe;
    sb_entry_t              r_mem;
    logic [STALL_CNT_W-1:0] r_stall_count;

    sb_entry_t w_mem_view;
    logic      w_exe_load_only;
    logic      w_mem_check_en;
    logic      w_m_exe_s1;
    logic      w_m_exe_s2;
    logic      w_m_mem_s1;
    logic      w_m_mem_s2;
    logic      w_raw;
    logic      w_issue;

`ifdef PIPE_SCHED_FORWARDING_EN
    // With forwarding, ALU results reach ID in time; only a load in EXE stalls.
    assign w_exe_load_only = 1'b1;
    assign w_mem_check_en  = 1'b0;
`else
    assign w_exe_load_only = 1'b0;
    assign w_mem_check_en  = 1'b1;
`endif

    // MEM entry as seen by the comparators; masked off when MEM never stalls.
    always_comb begin
        w_mem_view       = r_mem;
        w_mem_view.valid = r_mem.valid & w_mem_check_en;
    end

    sb_match u_match_exe_s1 (
        .i_entry     (r_exe),
        .i_src       (id_src1),
        .i_load_only (w_exe_load_only),
        .o_match     (w_m_exe_s1)
    );

    sb_match u_match_exe_s2 (
        .i_entry     (r_exe),
        .i_src       (id_src2),
        .i_load_only (w_exe_load_only),
        .o_match     (w_m_exe_s2)
    );

    sb_match u_match_mem_s1 (
        .i_entry     (w_mem_view),
        .i_src       (id_src1),
        .i_load_only (1'b0),
        .o_match     (w_m_mem_s1)
    );

    sb_match u_match_mem_s2 (
        .i_entry     (w_mem_view),
        .i_src       (id_src2),
        .i_load_only (1'b0),
        .o_match     (w_m_mem_s2)
    );

    // src2 only counts when the instruction really reads it.
    assign w_raw = id_valid
                 & ((w_m_exe_s1 | w_m_mem_s1)
                 | (id_two_src & (w_m_exe_s2 | w_m_mem_s2)));

    // A taken branch squashes ID anyway, so it overrides the stall.
    assign flush   = branch_taken;
    assign hazard  = w_raw & ~branch_taken;
    assign freeze  = hazard;
    assign w_issue = id_valid & ~hazard & ~branch_taken;

    assign stall_count = r_stall_count;

    // Scoreboard shift (ID -> EXE -> MEM) and saturating stall counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_exe         <= SB_EMPTY;
            r_mem         <= SB_EMPTY;
            r_stall_count <= STALL_CNT_ZERO;
        end else begin
            r_mem <= r_exe;
            if (w_issue) begin
                r_exe <= '{
                    valid:    1'b1,
                    dest:     id_dest,
                    wb_en:    id_wb_en,
                    mem_read: id_mem_read
                };
            end else begin
                r_exe <= SB_EMPTY;
            end
            if (hazard) begin
                r_stall_count <= stall_sat_inc(r_stall_count);
            end else begin
                r_stall_count <= r_stall_count;
            end
        end
    end

endmodule

// File: doc/pipe_sched.md
PIPE_SCHED -- requirements
Module: pipe_sched

Interface
REQ-001 SHALL have one clock `clk`; reset `rst` SHALL be synchronous and active-high.
REQ-002 Ports SHALL be, in order:
- clk  in  1  pipeline clock
- rst  in  1  synchronous active-high reset
- id_valid  in  1  ID holds a real instruction
- id_src1  in  4  Rn address in ID
- id_src2  in  4  second source address in ID (Rm, or Rd for stores)
- id_two_src  in  1  id_src2 is actually read
- id_dest  in  4  Rd address in ID
- id_wb_en  in  1  ID instruction writes the register file
- id_mem_read  in  1  ID instruction is a load
- branch_taken  in  1  branch resolved taken in EXE this cycle
- hazard  out  1  insert bubble into ID/EXE (drives ID-stage control mux)
- freeze  out  1  hold PC and IF/ID registers
- flush  out  1  clear IF/ID and ID/EXE
- stall_count  out  16  saturating count of hazard cycles

Function
REQ-003 SHALL keep a two-entry scoreboard, EXE and MEM, each entry being {valid, dest[3:0], wb_en, mem_read}.
REQ-004 Each clock edge: MEM SHALL take EXE; EXE SHALL take the ID fields when id_valid=1 and hazard=0 and flush=0, otherwise EXE.valid SHALL become 0.
REQ-005 An entry SHALL match source S when valid=1, wb_en=1 and dest==S.
REQ-006 A raw hazard SHALL exist when id_valid=1 and an entry matches id_src1, or id_two_src=1 and an entry matches id_src2.
REQ-007 Hazard, freeze and flush SHALL be combinational from the inputs and the registered scoreboard, with zero-cycle latency.
REQ-008 flush SHALL equal branch_taken.
REQ-009 hazard SHALL equal raw hazard AND NOT flush, because flush has priority.
REQ-010 freeze SHALL equal hazard.
REQ-011 A hazard SHALL persist cycle by cycle until the matching entry leaves MEM; without forwarding that is at most 2 consecutive hazard cycles per producer.
REQ-012 Register address 15 SHALL be compared like any other address, with no special case.
REQ-013 stall_count SHALL increment on every clock with hazard=1 and hold at 16'hFFFF without wrapping.
REQ-014 When id_valid=0, hazard SHALL be 0 and a bubble SHALL enter EXE.

Reset
REQ-015 When rst=1 at a clock edge, both scoreboard entries SHALL be invalidated and stall_count SHALL be set to 0, overriding all other updates.
REQ-016 Reset asserted mid-stall SHALL deassert hazard and freeze in the cycle after the edge, provided branch_taken=0 and no new match exists.

Configuration
REQ-017 Macro `PIPE_SCHED_FORWARDING_EN` SHALL select the hazard rule:
- Defined: REQ-006 SHALL apply only to the EXE entry, and only when EXE.mem_read=1 (load-use, 1 stall cycle).
- Undefined: REQ-006 SHALL apply to both EXE and MEM as written.

Structure
REQ-018 Shared package `pipe_pkg` SHALL hold REGFILE_ADDRESS_LEN=4, the scoreboard-entry typedef, and the stall-counter width of 16.
REQ-019 A sub-module `sb_match` SHALL take one entry and one source address and return the match bit; pipe_sched SHALL instantiate it 4 times (2 entries x 2 sources).

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- No-forwarding build, ADD R3 (dest=3, wb_en) then SUB reading src1=3 -> hazard=1 for 2 cycles, then 0; stall_count=2.
- Forwarding build, LDR R5 (mem_read) then ADD src2=5 with two_src=1 -> hazard=1 for exactly 1 cycle; stall_count=1.
- Producer dest=4 with id_two_src=0 and id_src2=4 -> hazard=0.
- Raw hazard present and branch_taken=1 in the same cycle -> flush=1, hazard=0, freeze=0; EXE invalid next cycle.
- rst=1 pulsed during a stall -> stall_count=0, hazard=0 in the following cycle.
- Force stall_count to 16'hFFFE, then 3 hazard cycles -> stall_count stays at 16'hFFFF.
